regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter for the 32×32 register file. It shares the register file's single write port between two writeback sources: the ALU and the load/store unit (LSU). Each source gets a one-entry holding slot behind a valid/ready handshake. A pending-write mask is exported so decode can stall on registers whose write has not yet landed. The block sits between the execute/memory stages and the register file's `we`/`rd`/`wdata` inputs.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `NREG`, default 32: number of architectural registers; address width is log2(NREG) = 5.

Ports:
- `clk`  in  1  clock, all state changes on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU slot can accept this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `lsu_valid`  in  1  LSU writeback request
- `lsu_ready`  out  1  LSU slot can accept this cycle
- `lsu_rd`  in  5  LSU destination register
- `lsu_data`  in  XLEN  load data
- `rf_we`  out  1  register file write enable
- `rf_rd`  out  5  register file write address
- `rf_wdata`  out  XLEN  register file write data
- `pending`  out  NREG  bit r = 1 while a held write targets register r
- `grant_lsu`  out  1  current `rf_*` write comes from the LSU slot (debug/perf)

## Operation
- Each source has its own slot with state `{full, rd, data}`. Slots reset to `full=0`.
- A transfer occurs on a posedge where `valid && ready` are both high. The slot then loads `rd` and `data` and sets `full=1`.
- `rd==0` requests are accepted but discarded. The slot stays empty, and no `rf_we` or `pending` bit is produced.
- `ready = !full || granted_this_cycle`. A draining slot accepts a new request on the same edge, giving back-to-back throughput of 1 per cycle per source.
- Arbitration is combinational over full slots:
  - Exactly one slot full: that slot is granted.
  - Both slots full: the round-robin pointer decides (see Configuration).
- Granted slot drives `rf_we=1`, `rf_rd`, and `rf_wdata`. The register file writes on the next posedge, and the slot clears on that same edge unless it is reloaded.
- No slot full: `rf_we=0`, `rf_rd=0`, `rf_wdata=0`, `grant_lsu=0`.
- `pending` is the OR of one-hot(`rd`) over full slots. It is derived from registered state only, so there is no combinational path from `*_valid`.
- Both slots holding the same `rd`: the writes land in grant order, and the later grant's data survives. Keeping program order is decode's job; it stalls on `pending`.

## Timing
- Reset values: `alu_ready=1`, `lsu_ready=1`, `rf_we=0`, `rf_rd=0`, `rf_wdata=0`, `pending=0`, `grant_lsu=0`, round-robin pointer = ALU preferred.
- Latency, uncontended: accept on edge E0 → `rf_we` high in cycle E0..E1 → register file updated on E1.
- Latency, contended: the loser waits exactly one extra cycle. The loser's `ready` is low while it waits, and no request is dropped.
- Round-robin pointer update: on each edge with both slots full, the pointer moves to the non-granted source. The pointer is unchanged otherwise.
- Reset asserted mid-operation: slots clear asynchronously, held writes are lost, and `rf_we` drops immediately.
- Simultaneous accept on both sources with both slots empty: both load on the same edge, and arbitration applies from the next cycle.

## Configuration
- `REGFILE_WBARB_RR_EN` defined: round-robin between ALU and LSU on contention, with the pointer as above.
- `REGFILE_WBARB_RR_EN` undefined: fixed priority, LSU always wins on contention. The pointer register is not built, and the ALU can be stalled indefinitely by back-to-back loads.

## Structure
- Shared package `regfile_pkg`:
  - constants `XLEN=32`, `NREG=32`, `REG_AW=5`
  - typedef `reg_addr_t` (5 bits)
  - typedef `wb_src_e` {`WB_ALU=0`, `WB_LSU=1`}
  - struct `wb_req_t` {`rd`, `data`}
- Sub-module `regfile_wb_slot`: one-entry holding slot with `valid`/`ready`/`grant`/`full` and an x0 filter. It is instantiated twice.
- The top level holds the arbiter, the round-robin pointer, the pending-mask decode and the output mux.

## Test plan
1. Reset, then ALU writes `rd=5`, `data=0xDEADBEEF` → next cycle `rf_we=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF`, `pending[5]=1`; the following cycle `pending=0`.
2. Both sources valid in the same cycle (ALU `rd=3`/`0x11`, LSU `rd=4`/`0x22`), RR build → cycle 1 writes ALU (`rd=3`) with `lsu_ready=0`; cycle 2 writes LSU (`rd=4`).
3. Sustained contention for 8 cycles, RR build → grants alternate ALU/LSU. In the fixed build, `alu_ready` stays 0 while the LSU streams.
4. ALU `rd=0`, `data=0xFFFFFFFF` → accepted, `rf_we` stays 0, `pending` stays 0.
5. Both slots hold `rd=7` (ALU `0xA`, LSU `0xB`), RR with pointer at ALU → two writes in order `0xA` then `0xB`, and `pending[7]` clears after the second.
6. `rst_n` pulsed low while both slots are full → `rf_we` drops in the same cycle, `pending=0`, both `ready=1`; no write occurs after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU sources, the arbiter and the register file port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  import regfile_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  reg_addr_t       lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            rf_we;
  reg_addr_t       rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] pending;
  logic            grant_lsu;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_rd, rf_wdata, pending, grant_lsu
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rf_we, rf_rd, rf_wdata, pending, grant_lsu
  );

endinterface

// File: rtl/regfile_wb_slot.sv
// One-entry writeback holding slot; writes to x0 are accepted and dropped.
module regfile_wb_slot #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  output logic                  ready,
  input  regfile_pkg::reg_addr_t in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  grant,
  output logic                  full,
  output regfile_pkg::reg_addr_t rd,
  output logic [XLEN-1:0]       data
);
  import regfile_pkg::*;

  // A granted slot drains this edge, so it can take a new request at the same time.
  assign ready = !full || grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (valid && ready) begin
      if (in_rd != '0) begin
        full <= 1'b1;
        rd   <= in_rd;
        data <= in_data;
      end else begin
        full <= 1'b0;
      end
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and LSU writeback slots.
// Define REGFILE_WBARB_RR_EN for round-robin on contention; otherwise the LSU always wins.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic                clk,
  input logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_pkg::*;

  logic            alu_full, lsu_full;
  logic            alu_gnt, lsu_gnt, lsu_win;
  reg_addr_t       alu_hold_rd, lsu_hold_rd;
  logic [XLEN-1:0] alu_hold_data, lsu_hold_data;
  logic [NREG-1:0] pend;

  regfile_wb_slot #(.XLEN(XLEN)) u_alu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (bus.alu_valid),
    .ready   (bus.alu_ready),
    .in_rd   (bus.alu_rd),
    .in_data (bus.alu_data),
    .grant   (alu_gnt),
    .full    (alu_full),
    .rd      (alu_hold_rd),
    .data    (alu_hold_data)
  );

  regfile_wb_slot #(.XLEN(XLEN)) u_lsu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (bus.lsu_valid),
    .ready   (bus.lsu_ready),
    .in_rd   (bus.lsu_rd),
    .in_data (bus.lsu_data),
    .grant   (lsu_gnt),
    .full    (lsu_full),
    .rd      (lsu_hold_rd),
    .data    (lsu_hold_data)
  );

`ifdef REGFILE_WBARB_RR_EN
  wb_src_e rr_ptr;

  assign lsu_win = lsu_full && (!alu_full || (rr_ptr == WB_LSU));

  // Only contention moves the pointer, and it always moves to the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= WB_ALU;
    end else if (alu_full && lsu_full) begin
      rr_ptr <= lsu_win ? WB_ALU : WB_LSU;
    end
  end
`else
  assign lsu_win = lsu_full;
`endif

  assign lsu_gnt = lsu_win;
  assign alu_gnt = alu_full && !lsu_win;

  always_comb begin
    bus.rf_we     = alu_full || lsu_full;
    bus.rf_rd     = '0;
    bus.rf_wdata  = '0;
    bus.grant_lsu = lsu_gnt;
    if (lsu_gnt) begin
      bus.rf_rd    = lsu_hold_rd;
      bus.rf_wdata = lsu_hold_data;
    end else if (alu_gnt) begin
      bus.rf_rd    = alu_hold_rd;
      bus.rf_wdata = alu_hold_data;
    end
  end

  // Built from slot state only, so decode never sees a path from the valids.
  always_comb begin
    pend = '0;
    if (alu_full) pend[alu_hold_rd] = 1'b1;
    if (lsu_full) pend[lsu_hold_rd] = 1'b1;
  end

  assign bus.pending = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; expectations follow REGFILE_WBARB_RR_EN when defined.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct packed {
    wb_src_e src;
    wb_req_t req;
  } exp_wr_t;

  logic    clk = 1'b0;
  logic    rst_n;
  int      checks = 0;
  int      failures = 0;
  exp_wr_t sb_q[$];
  wb_src_e rr_pref;
  wb_src_e w;
  int      ha, hl, na, nl;

  regfile_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input reg_addr_t ar, input logic [31:0] ad,
                               input logic lv, input reg_addr_t lr, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lr;
    bus.lsu_data  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner of the next contended cycle, advancing the expected pointer.
  task automatic contend(output wb_src_e win);
`ifdef REGFILE_WBARB_RR_EN
    win     = rr_pref;
    rr_pref = (rr_pref == WB_ALU) ? WB_LSU : WB_ALU;
`else
    win = WB_LSU;
`endif
  endtask

  function automatic exp_wr_t mk(input wb_src_e s, input reg_addr_t r, input logic [31:0] d);
    exp_wr_t e;
    e.src      = s;
    e.req.rd   = r;
    e.req.data = d;
    return e;
  endfunction

  function automatic reg_addr_t ard(input int i);
    return reg_addr_t'(8 + i);
  endfunction

  function automatic logic [31:0] adt(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic reg_addr_t lrd(input int i);
    return reg_addr_t'(16 + i);
  endfunction

  function automatic logic [31:0] ldt(input int i);
    return 32'hB000_0000 + 32'(i);
  endfunction

  always @(negedge clk) begin
    exp_wr_t e;
    if (bus.rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_write", bus.rf_we, 1'b0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("wr_rd", bus.rf_rd, e.req.rd);
        checkOutput("wr_data", bus.rf_wdata, e.req.data);
        checkOutput("wr_grant_lsu", bus.grant_lsu, e.src == WB_LSU);
      end
    end else begin
      checkOutput("idle_rd", bus.rf_rd, '0);
      checkOutput("idle_wdata", bus.rf_wdata, '0);
      checkOutput("idle_grant_lsu", bus.grant_lsu, 1'b0);
    end
  end

  initial begin
    rst_n   = 1'b0;
    rr_pref = WB_ALU;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("rst_alu_ready", bus.alu_ready, 1'b1);
    checkOutput("rst_lsu_ready", bus.lsu_ready, 1'b1);
    checkOutput("rst_rf_we", bus.rf_we, 1'b0);
    checkOutput("rst_rf_rd", bus.rf_rd, 5'd0);
    checkOutput("rst_rf_wdata", bus.rf_wdata, 32'h0);
    checkOutput("rst_pending", bus.pending, 32'h0);
    checkOutput("rst_grant_lsu", bus.grant_lsu, 1'b0);

    // Single uncontended ALU write.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    sb_q.push_back(mk(WB_ALU, 5'd5, 32'hDEAD_BEEF));
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("t1_rf_we", bus.rf_we, 1'b1);
    checkOutput("t1_pending", bus.pending, 32'h0000_0020);
    tick();
    checkOutput("t1_rf_we_after", bus.rf_we, 1'b0);
    checkOutput("t1_pending_after", bus.pending, 32'h0);

    // Simultaneous accept on both sources.
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    contend(w);
    if (w == WB_ALU) begin
      sb_q.push_back(mk(WB_ALU, 5'd3, 32'h11));
      sb_q.push_back(mk(WB_LSU, 5'd4, 32'h22));
    end else begin
      sb_q.push_back(mk(WB_LSU, 5'd4, 32'h22));
      sb_q.push_back(mk(WB_ALU, 5'd3, 32'h11));
    end
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("t2_alu_ready", bus.alu_ready, w == WB_ALU);
    checkOutput("t2_lsu_ready", bus.lsu_ready, w == WB_LSU);
    checkOutput("t2_pending_both", bus.pending, 32'h0000_0018);
    tick();
    checkOutput("t2_pending_loser", bus.pending, (w == WB_ALU) ? 32'h0000_0010 : 32'h0000_0008);
    tick();
    checkOutput("t2_pending_clear", bus.pending, 32'h0);

    // Sustained contention: each source offers its next item once the previous was taken.
    applyStimulus(1'b1, ard(0), adt(0), 1'b1, lrd(0), ldt(0));
    tick();
    ha = 0; hl = 0; na = 1; nl = 1;
    applyStimulus(1'b1, ard(na), adt(na), 1'b1, lrd(nl), ldt(nl));
    for (int c = 0; c < 8; c++) begin
      contend(w);
      checkOutput("t3_alu_ready", bus.alu_ready, w == WB_ALU);
      checkOutput("t3_lsu_ready", bus.lsu_ready, w == WB_LSU);
      if (w == WB_ALU) sb_q.push_back(mk(WB_ALU, ard(ha), adt(ha)));
      else             sb_q.push_back(mk(WB_LSU, lrd(hl), ldt(hl)));
      tick();
      if (w == WB_ALU) begin
        ha = na;
        na++;
      end else begin
        hl = nl;
        nl++;
      end
      applyStimulus(1'b1, ard(na), adt(na), 1'b1, lrd(nl), ldt(nl));
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("t3_pending_drain", bus.pending, (32'h1 << ard(ha)) | (32'h1 << lrd(hl)));
    contend(w);
    if (w == WB_ALU) begin
      sb_q.push_back(mk(WB_ALU, ard(ha), adt(ha)));
      sb_q.push_back(mk(WB_LSU, lrd(hl), ldt(hl)));
    end else begin
      sb_q.push_back(mk(WB_LSU, lrd(hl), ldt(hl)));
      sb_q.push_back(mk(WB_ALU, ard(ha), adt(ha)));
    end
    repeat (3) tick();
    checkOutput("t3_pending_clear", bus.pending, 32'h0);

    // Write to x0 is swallowed.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("t4_alu_ready", bus.alu_ready, 1'b1);
    checkOutput("t4_rf_we", bus.rf_we, 1'b0);
    checkOutput("t4_pending", bus.pending, 32'h0);
    tick();
    checkOutput("t4_rf_we_later", bus.rf_we, 1'b0);

    // Same destination from both sources.
    applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    contend(w);
    if (w == WB_ALU) begin
      sb_q.push_back(mk(WB_ALU, 5'd7, 32'hA));
      sb_q.push_back(mk(WB_LSU, 5'd7, 32'hB));
    end else begin
      sb_q.push_back(mk(WB_LSU, 5'd7, 32'hB));
      sb_q.push_back(mk(WB_ALU, 5'd7, 32'hA));
    end
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("t5_pending_first", bus.pending, 32'h0000_0080);
    tick();
    checkOutput("t5_pending_second", bus.pending, 32'h0000_0080);
    checkOutput("t5_second_data", bus.rf_wdata, (w == WB_ALU) ? 32'hB : 32'hA);
    tick();
    checkOutput("t5_pending_clear", bus.pending, 32'h0);

    // Reset while both slots hold writes: nothing may land.
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("t6_rf_we_before", bus.rf_we, 1'b1);
    checkOutput("t6_pending_before", bus.pending, 32'h0000_0600);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rf_we_rst", bus.rf_we, 1'b0);
    checkOutput("t6_pending_rst", bus.pending, 32'h0);
    checkOutput("t6_alu_ready_rst", bus.alu_ready, 1'b1);
    checkOutput("t6_lsu_ready_rst", bus.lsu_ready, 1'b1);
    #2 rst_n = 1'b1;
    rr_pref = WB_ALU;
    repeat (3) tick();
    checkOutput("t6_rf_we_after", bus.rf_we, 1'b0);
    checkOutput("sb_leftover", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
